// File: rtl/mem_arbiter_if.sv
// Pipeline-side fetch/load-store ports and the shared memory bus, bundled for the arbiter.
// The arbiter uses the slave view; the pipeline and memory model together use the master view.
interface mem_arbiter_if;
    logic        inst_req_valid;
    logic        inst_req_ready;
    logic [63:0] inst_addr;
    logic        inst_flush;
    logic        inst_resp_valid;
    logic [31:0] inst_rdata;

    logic        data_req_valid;
    logic        data_req_ready;
    logic        data_wr;
    logic [63:0] data_addr;
    logic [63:0] data_wdata;
    logic [7:0]  data_wmask;
    logic        data_resp_valid;
    logic [63:0] data_rdata;

    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_wr;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wmask;
    logic        bus_resp_valid;
    logic [63:0] bus_rdata;

    modport slave (
        input  inst_req_valid, inst_addr, inst_flush,
        output inst_req_ready, inst_resp_valid, inst_rdata,
        input  data_req_valid, data_wr, data_addr, data_wdata, data_wmask,
        output data_req_ready, data_resp_valid, data_rdata,
        output bus_req_valid, bus_wr, bus_addr, bus_wdata, bus_wmask,
        input  bus_req_ready, bus_resp_valid, bus_rdata
    );

    modport master (
        output inst_req_valid, inst_addr, inst_flush,
        input  inst_req_ready, inst_resp_valid, inst_rdata,
        output data_req_valid, data_wr, data_addr, data_wdata, data_wmask,
        input  data_req_ready, data_resp_valid, data_rdata,
        input  bus_req_valid, bus_wr, bus_addr, bus_wdata, bus_wmask,
        output bus_req_ready, bus_resp_valid, bus_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory bus between instruction fetch and load/store with one outstanding
// transaction, data priority, bounded fetch starvation and flush-dropped fetch responses.
module mem_arbiter #(
    parameter int unsigned DATA_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  ifc,
    output logic          busy
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
    typedef enum logic {OWN_DATA, OWN_INST} owner_t;

    localparam logic [3:0] STREAK_MAX = 4'(DATA_MAX);

    state_t      r_state;
    state_t      w_state_next;
    owner_t      r_owner;
    logic        r_wr;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [7:0]  r_wmask;
    logic        r_sel;
    logic        r_drop;
    logic [3:0]  r_streak;
    logic        r_inst_resp_valid;
    logic [31:0] r_inst_rdata;
    logic        r_data_resp_valid;
    logic [63:0] r_data_rdata;

    logic w_idle;
    logic w_inst_wins;
    logic w_inst_hs;
    logic w_data_hs;
    logic w_resp_done;
    logic w_unused_addr_bits;

    // The fetch wins only when data is absent or data has won DATA_MAX contended grants in a row.
    assign w_inst_wins = ifc.inst_req_valid && !ifc.inst_flush &&
                         (!ifc.data_req_valid || r_streak == STREAK_MAX);
    assign w_idle      = (r_state == S_IDLE) && !rst;
    assign w_inst_hs   = w_idle && w_inst_wins;
    assign w_data_hs   = w_idle && ifc.data_req_valid && !w_inst_wins;
    assign w_resp_done = (r_state == S_RESP) && ifc.bus_resp_valid;

    // NOTE: sequential state uses <= so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latch).
        w_state_next       = r_state;
        ifc.inst_req_ready = 1'b0;
        ifc.data_req_ready = 1'b0;
        ifc.bus_req_valid  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                ifc.inst_req_ready = w_inst_hs;
                ifc.data_req_ready = w_data_hs;
                if (w_inst_hs || w_data_hs) w_state_next = S_REQ;
            end
            S_REQ: begin
                ifc.bus_req_valid = 1'b1;
                if (ifc.bus_req_ready) w_state_next = S_RESP;
            end
            S_RESP: begin
                if (ifc.bus_resp_valid) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner           <= OWN_DATA;
            r_wr              <= 1'b0;
            r_addr            <= '0;
            r_wdata           <= '0;
            r_wmask           <= '0;
            r_sel             <= 1'b0;
            r_drop            <= 1'b0;
            r_streak          <= '0;
            r_inst_resp_valid <= 1'b0;
            r_inst_rdata      <= '0;
            r_data_resp_valid <= 1'b0;
            r_data_rdata      <= '0;
        end else begin
            r_inst_resp_valid <= 1'b0;
            r_data_resp_valid <= 1'b0;

            if (w_inst_hs) begin
                r_owner  <= OWN_INST;
                r_wr     <= 1'b0;
                r_addr   <= {ifc.inst_addr[63:3], 3'b000};
                r_wdata  <= '0;
                r_wmask  <= '0;
                r_sel    <= ifc.inst_addr[2];
                r_streak <= '0;
            end else if (w_data_hs) begin
                r_owner <= OWN_DATA;
                r_wr    <= ifc.data_wr;
                r_addr  <= ifc.data_addr;
                r_wdata <= ifc.data_wdata;
                r_wmask <= ifc.data_wmask;
                if (ifc.inst_req_valid && r_streak != STREAK_MAX) r_streak <= r_streak + 4'd1;
            end

            // A flush on the response cycle itself must also kill the fetch, hence the live inst_flush term.
            if (w_resp_done) begin
                r_drop <= 1'b0;
                if (r_owner == OWN_DATA) begin
                    r_data_resp_valid <= 1'b1;
                    r_data_rdata      <= ifc.bus_rdata;
                end else if (!r_drop && !ifc.inst_flush) begin
                    r_inst_resp_valid <= 1'b1;
                    r_inst_rdata      <= r_sel ? ifc.bus_rdata[63:32] : ifc.bus_rdata[31:0];
                end
            end else if (ifc.inst_flush && r_owner == OWN_INST && r_state != S_IDLE) begin
                r_drop <= 1'b1;
            end
        end
    end

    assign ifc.bus_wr          = r_wr;
    assign ifc.bus_addr        = r_addr;
    assign ifc.bus_wdata       = r_wdata;
    assign ifc.bus_wmask       = r_wmask;
    assign ifc.inst_resp_valid = r_inst_resp_valid;
    assign ifc.inst_rdata      = r_inst_rdata;
    assign ifc.data_resp_valid = r_data_resp_valid;
    assign ifc.data_rdata      = r_data_rdata;
    assign busy                = (r_state != S_IDLE);

    // Fetch addresses are word aligned; the two low bits carry no information.
    assign w_unused_addr_bits = ^ifc.inst_addr[1:0];

endmodule
